weight_bank: RTL and testbench

WEIGHT_BANK -- requirements
Module: weight_bank

---
 rtl/weight_bank.sv | 131 +++++++++++++
 tb/tb_weight_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank.sv
// Multi-channel weight store: a streamed reload fills every channel in order,
// and one address reads the same word from all channels in parallel.
module weight_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_load_start,
    input  logic                         i_s_valid,
    input  logic [DATA_WIDTH-1:0]        i_s_data,
    output logic                         o_s_ready,
    output logic                         o_load_busy,
    output logic                         o_load_done,
    input  logic                         i_ren,
    input  logic [ADDR_WIDTH-1:0]        i_raddr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic                         o_rvalid,
    output logic                         o_rd_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WD = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
    logic [ADDR_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic                  wr_en;
    logic                  rd_accept;
    logic                  rd_reject;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        wr_en       = 1'b0;
        o_s_ready   = 1'b0;
        o_load_busy = 1'b0;
        o_load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load_start) begin
                    state_d  = LOAD;
                    ch_cnt_d = '0;
                    wd_cnt_d = '0;
                end
            end
            LOAD: begin
                o_s_ready   = 1'b1;
                o_load_busy = 1'b1;
                if (i_s_valid) begin
                    wr_en = 1'b1;
                    if (wd_cnt_q == LAST_WD) begin
                        wd_cnt_d = '0;
                        if (ch_cnt_q == LAST_CH) begin
                            state_d = DONE;
                        end else begin
                            ch_cnt_d = ch_cnt_q + CH_W'(1);
                        end
                    end else begin
                        wd_cnt_d = wd_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                o_load_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ch_cnt_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign rd_accept = i_ren && (state_q != LOAD);
    assign rd_reject = i_ren && (state_q == LOAD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rvalid <= 1'b0;
            o_rd_err <= 1'b0;
        end else begin
            o_rvalid <= rd_accept;
            o_rd_err <= rd_reject;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rdata_q;

        // NOTE: the array has no reset so it maps onto RAM and survives an aborted reload.
        always_ff @(posedge i_clk) begin
            if (wr_en && (ch_cnt_q == CH_W'(k))) begin
                mem[wd_cnt_q] <= i_s_data;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rdata_q <= '0;
            end else if (rd_accept) begin
                rdata_q <= mem[i_raddr];
            end
        end

        assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank with two channels of four 16-bit words:
// full, stalled and interrupted reloads plus single and back-to-back reads.
module tb_weight_bank;

    localparam int DW  = 16;
    localparam int AW  = 2;
    localparam int NCH = 2;
    localparam int DEP = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_load_start;
    logic              i_s_valid;
    logic [DW-1:0]     i_s_data;
    logic              o_s_ready;
    logic              o_load_busy;
    logic              o_load_done;
    logic              i_ren;
    logic [AW-1:0]     i_raddr;
    logic [NCH*DW-1:0] o_data;
    logic              o_rvalid;
    logic              o_rd_err;

    int checks = 0;
    int errors = 0;

    weight_bank #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_CH    (NCH),
        .DEPTH     (DEP)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load_start(i_load_start),
        .i_s_valid   (i_s_valid),
        .i_s_data    (i_s_data),
        .o_s_ready   (o_s_ready),
        .o_load_busy (o_load_busy),
        .o_load_done (o_load_done),
        .i_ren       (i_ren),
        .i_raddr     (i_raddr),
        .o_data      (o_data),
        .o_rvalid    (o_rvalid),
        .o_rd_err    (o_rd_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic read_one(input logic [AW-1:0] addr, input logic [31:0] expected, input string tag);
        i_ren   = 1'b1;
        i_raddr = addr;
        tick();
        i_ren = 1'b0;
        check({tag, "_rvalid"}, 32'(o_rvalid), 32'd1);
        check({tag, "_data"}, o_data, expected);
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_load_start = 1'b0;
        i_s_valid    = 1'b0;
        i_s_data     = '0;
        i_ren        = 1'b0;
        i_raddr      = '0;

        // Reset state
        #12;
        check("rst_ready", 32'(o_s_ready), 32'd0);
        check("rst_busy", 32'(o_load_busy), 32'd0);
        check("rst_done", 32'(o_load_done), 32'd0);
        check("rst_rvalid", 32'(o_rvalid), 32'd0);
        check("rst_rderr", 32'(o_rd_err), 32'd0);
        check("rst_data", o_data, 32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Full continuous load of 0x0010..0x0017; start on the first edge after release
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        check("full_ready", 32'(o_s_ready), 32'd1);
        check("full_busy", 32'(o_load_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            i_s_valid = 1'b1;
            i_s_data  = 16'h0010 + 16'(i);
            tick();
            if (i == 6) check("full_done_early", 32'(o_load_done), 32'd0);
        end
        i_s_valid = 1'b0;
        check("full_done", 32'(o_load_done), 32'd1);
        check("full_done_ready", 32'(o_s_ready), 32'd0);
        check("full_done_busy", 32'(o_load_busy), 32'd0);
        tick();
        check("full_done_pulse", 32'(o_load_done), 32'd0);
        read_one(2'd2, 32'h0016_0012, "full_rd2");
        tick();
        check("full_rvalid_drop", 32'(o_rvalid), 32'd0);
        check("full_data_hold", o_data, 32'h0016_0012);

        // Stalled load of 0x0020..0x0027 with a gap after every word
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_s_valid = 1'b1;
            i_s_data  = 16'h0020 + 16'(i);
            tick();
            if (i < 7) begin
                check("stall_busy_word", 32'(o_load_busy), 32'd1);
                i_s_valid = 1'b0;
                i_s_data  = 16'hDEAD;
                tick();
                check("stall_busy_gap", 32'(o_load_busy), 32'd1);
                check("stall_no_done", 32'(o_load_done), 32'd0);
            end
        end
        check("stall_done", 32'(o_load_done), 32'd1);
        // In the DONE cycle: read new contents; stray stream word and start must be ignored
        i_ren        = 1'b1;
        i_raddr      = 2'd3;
        i_s_valid    = 1'b1;
        i_s_data     = 16'hBEEF;
        i_load_start = 1'b1;
        tick();
        i_ren        = 1'b0;
        i_s_valid    = 1'b0;
        i_load_start = 1'b0;
        check("done_rd_rvalid", 32'(o_rvalid), 32'd1);
        check("done_rd_data", o_data, 32'h0027_0023);
        check("done_start_ignored", 32'(o_s_ready), 32'd0);

        // Back-to-back reads of addresses 0..3
        i_ren = 1'b1;
        for (int a = 0; a < 4; a++) begin
            logic [15:0] e0;
            logic [15:0] e1;
            e0      = 16'h0020 + 16'(a);
            e1      = 16'h0024 + 16'(a);
            i_raddr = AW'(a);
            tick();
            check("b2b_rvalid", 32'(o_rvalid), 32'd1);
            check("b2b_data", o_data, {e1, e0});
        end
        i_ren = 1'b0;
        tick();
        check("b2b_rvalid_drop", 32'(o_rvalid), 32'd0);

        // Load 0x0030..0x0037 with a rejected read at word 3 and a stray start at word 5
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_s_valid = 1'b1;
            i_s_data  = 16'h0030 + 16'(i);
            if (i == 3) begin
                i_ren   = 1'b1;
                i_raddr = 2'd0;
            end
            if (i == 5) i_load_start = 1'b1;
            tick();
            i_ren        = 1'b0;
            i_load_start = 1'b0;
            if (i == 3) begin
                check("rdload_err", 32'(o_rd_err), 32'd1);
                check("rdload_rvalid", 32'(o_rvalid), 32'd0);
                check("rdload_data_hold", o_data, 32'h0027_0023);
            end
            if (i == 4) check("rdload_err_pulse", 32'(o_rd_err), 32'd0);
        end
        i_s_valid = 1'b0;
        check("rdload_done", 32'(o_load_done), 32'd1);
        tick();
        // Stream word while idle must not be written
        i_s_valid = 1'b1;
        i_s_data  = 16'hBAD0;
        tick();
        i_s_valid = 1'b0;
        check("idle_ready", 32'(o_s_ready), 32'd0);
        read_one(2'd0, 32'h0034_0030, "rdload_rd0");
        read_one(2'd3, 32'h0037_0033, "rdload_rd3");

        // Reset after 5 of 8 words of a 0x0040.. stream
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_s_valid = 1'b1;
            i_s_data  = 16'h0040 + 16'(i);
            tick();
        end
        i_s_valid = 1'b0;
        i_rst_n   = 1'b0;
        #1;
        check("midrst_busy", 32'(o_load_busy), 32'd0);
        check("midrst_ready", 32'(o_s_ready), 32'd0);
        check("midrst_data", o_data, 32'h0);
        check("midrst_done", 32'(o_load_done), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        read_one(2'd0, 32'h0044_0040, "midrst_rd0");
        check("midrst_busy_after", 32'(o_load_busy), 32'd0);
        check("midrst_no_done", 32'(o_load_done), 32'd0);
        read_one(2'd1, 32'h0035_0041, "midrst_rd1");
        read_one(2'd3, 32'h0037_0043, "midrst_rd3");
        check("midrst_no_done_end", 32'(o_load_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
